// File: rtl/coherence_bus_ctrl.sv
// coherence_bus_ctrl: memory-side responder for two coherent dcaches and two
// icaches sharing one RAM port. One transaction is in flight at a time.
// Ports:
//   CLK, RST                       clock, synchronous active-high reset
//   iREN/iaddr -> iwait/iload      icache fetch request / stall and data
//   dREN/dWEN/daddr/dstore         dcache read/write request, address, data
//   cctrans/ccwrite                coherence transition start / write intent
//   dwait/dload                    dcache stall and read data
//   ccwait/ccinv/ccsnoopaddr       snoop controls toward each dcache
//   ramREN/ramWEN/ramaddr/ramstore RAM request
//   ramload/ramstate               RAM read data and beat status
module coherence_bus_ctrl #(
  parameter int unsigned CPUS = 2
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [CPUS-1:0]      iREN,
  input  logic [CPUS-1:0][31:0] iaddr,
  output logic [CPUS-1:0]      iwait,
  output logic [CPUS-1:0][31:0] iload,
  input  logic [CPUS-1:0]      dREN,
  input  logic [CPUS-1:0]      dWEN,
  input  logic [CPUS-1:0][31:0] daddr,
  input  logic [CPUS-1:0][31:0] dstore,
  input  logic [CPUS-1:0]      cctrans,
  input  logic [CPUS-1:0]      ccwrite,
  output logic [CPUS-1:0]      dwait,
  output logic [CPUS-1:0][31:0] dload,
  output logic [CPUS-1:0]      ccwait,
  output logic [CPUS-1:0]      ccinv,
  output logic [CPUS-1:0][31:0] ccsnoopaddr,
  output logic                 ramREN,
  output logic                 ramWEN,
  output logic [31:0]          ramaddr,
  output logic [31:0]          ramstore,
  input  logic [31:0]          ramload,
  input  logic [1:0]           ramstate
);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_ARB    = 4'd1;
  localparam logic [3:0] S_SNOOP  = 4'd2;
  localparam logic [3:0] S_SNPCHK = 4'd3;
  localparam logic [3:0] S_RD0    = 4'd4;
  localparam logic [3:0] S_RD1    = 4'd5;
  localparam logic [3:0] S_FWD0   = 4'd6;
  localparam logic [3:0] S_FWD1   = 4'd7;
  localparam logic [3:0] S_WB0    = 4'd8;
  localparam logic [3:0] S_WB1    = 4'd9;
  localparam logic [3:0] S_INV    = 4'd10;
  localparam logic [3:0] S_IFETCH = 4'd11;

  localparam logic [1:0] RAM_ACCESS = 2'd2;

  logic [3:0]      state, state_n, cur;
  logic            sel, sel_n;       // granted cache (dcache or icache index)
  logic            dptr, dptr_n;     // dcache round-robin pointer
  logic            iptr, iptr_n;     // icache round-robin pointer
  logic            inv_q, inv_n;     // requester write intent, held for the snoop
  logic            oth;
  logic            access;
  logic            fwd_sig;
  logic            dpick, ipick;
  logic [CPUS-1:0] dreq;

  assign oth    = ~sel;
  assign access = (ramstate == RAM_ACCESS);
  assign dreq   = dREN | dWEN | cctrans;
  assign dpick  = (&dreq) ? dptr : dreq[1];
  assign ipick  = (&iREN) ? iptr : iREN[1];
  // Snooped cache answering with a modified block; a cache with its own
  // request pending never shows this pattern, so the fill falls back to RAM.
  assign fwd_sig = cctrans[oth] & ~dREN[oth] & ~dWEN[oth] & ~ccwrite[oth];
  // Reset suppresses all outputs immediately, abandoning any beat in progress.
  assign cur = RST ? S_IDLE : state;

  // State and arbitration registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= S_IDLE;
      sel   <= 1'b0;
      dptr  <= 1'b0;
      iptr  <= 1'b0;
      inv_q <= 1'b0;
    end else begin
      state <= state_n;
      sel   <= sel_n;
      dptr  <= dptr_n;
      iptr  <= iptr_n;
      inv_q <= inv_n;
    end
  end

  // Next-state, arbitration and bus outputs
  always_comb begin
    state_n     = state;
    sel_n       = sel;
    dptr_n      = dptr;
    iptr_n      = iptr;
    inv_n       = inv_q;
    dwait       = '1;
    iwait       = '1;
    ccwait      = '0;
    ccinv       = '0;
    ccsnoopaddr = '0;
    ramREN      = 1'b0;
    ramWEN      = 1'b0;
    ramaddr     = '0;
    ramstore    = '0;
    for (int k = 0; k < int'(CPUS); k++) begin
      dload[k] = ramload;
      iload[k] = ramload;
    end

    case (cur)
      S_IDLE: begin
        if (|{dREN, dWEN, cctrans, iREN}) state_n = S_ARB;
      end

      S_ARB: begin
        if (|dreq) begin
          sel_n = dpick;
          inv_n = ccwrite[dpick];
          if (dREN[dpick])                          state_n = S_SNOOP;
          else if (dWEN[dpick])                     state_n = S_WB0;
          else if (cctrans[dpick] & ccwrite[dpick]) state_n = S_INV;
          else                                      state_n = S_IDLE;
        end else if (|iREN) begin
          sel_n   = ipick;
          state_n = S_IFETCH;
        end else begin
          state_n = S_IDLE;
        end
      end

      S_SNOOP, S_SNPCHK, S_FWD0, S_FWD1: begin
        ccwait[oth]      = 1'b1;
        ccinv[oth]       = inv_q;
        ccsnoopaddr[oth] = {daddr[sel][31:3], 3'b000};
        if (cur == S_SNOOP)  state_n = S_SNPCHK;
        if (cur == S_SNPCHK) state_n = fwd_sig ? S_FWD0 : S_RD0;
        if (cur == S_FWD0 || cur == S_FWD1) begin
          // Forwarded block goes to the requester and back to RAM together.
          dload[sel] = dstore[oth];
          ramWEN     = 1'b1;
          ramaddr    = daddr[oth];
          ramstore   = dstore[oth];
          if (access) begin
            dwait[sel] = 1'b0;
            dwait[oth] = 1'b0;
            if (cur == S_FWD0) begin
              state_n = S_FWD1;
            end else begin
              state_n = S_IDLE;
              dptr_n  = oth;
            end
          end
        end
      end

      S_RD0, S_RD1: begin
        ramREN = 1'b1;
        ramaddr = daddr[sel];
        if (access) begin
          dwait[sel] = 1'b0;
          if (cur == S_RD0) begin
            state_n = S_RD1;
          end else begin
            state_n = S_IDLE;
            dptr_n  = oth;
          end
        end
      end

      S_WB0, S_WB1: begin
        ramWEN   = 1'b1;
        ramaddr  = daddr[sel];
        ramstore = dstore[sel];
        if (access) begin
          dwait[sel] = 1'b0;
          // A lone word write (cctrans low) finishes after the first beat.
          if (cur == S_WB0 && dWEN[sel] && cctrans[sel]) begin
            state_n = S_WB1;
          end else begin
            state_n = S_IDLE;
            dptr_n  = oth;
          end
        end
      end

      S_INV: begin
        ccwait[oth]      = 1'b1;
        ccinv[oth]       = 1'b1;
        ccsnoopaddr[oth] = daddr[sel];
        dwait[sel]       = 1'b0;
        state_n          = S_IDLE;
        dptr_n           = oth;
      end

      S_IFETCH: begin
        ramREN  = 1'b1;
        ramaddr = iaddr[sel];
        if (access) begin
          iwait[sel] = 1'b0;
          state_n    = S_IDLE;
          iptr_n     = oth;
        end
      end

      default: state_n = S_IDLE;
    endcase
  end

endmodule
